// File: rtl/cache_pkg.sv
// Shared types, policy constants and helpers for the trace-driven cache model.
package cache_pkg;

    // Trace access encodings; any other value is a no-op.
    typedef enum logic [31:0] {
        ACC_READ  = 32'd0,
        ACC_WRITE = 32'd1,
        ACC_INVAL = 32'd2
    } access_e;

    localparam int POLICY_TRUE_LRU = 0;
    localparam int POLICY_BIT_LRU  = 1;

    // Largest value a statistics counter may hold before it sticks.
    localparam int CNT_MAX = 32'sh7fff_ffff;

    // Number of address bits needed to select one of n items.
    function automatic int addr_bits(input int n);
        return $clog2(n);
    endfunction

    // Width for a vector selecting one of n items; never narrower than one bit.
    function automatic int field_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Saturating increment for the statistics counters.
    function automatic int sat_inc(input int v);
        return (v == CNT_MAX) ? v : v + 32'sd1;
    endfunction

endpackage

// File: rtl/cache_repl.sv
// Replacement state for one cache set: true LRU ages or one MRU bit per way.
module cache_repl
    import cache_pkg::*;
#(
    parameter int num_ways           = 8,
    parameter int replacement_policy = POLICY_TRUE_LRU,
    parameter int way_bits           = field_width(num_ways)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                touch,
    input  logic [way_bits-1:0] way_idx,
    output logic [way_bits-1:0] victim
);

    if (replacement_policy == POLICY_TRUE_LRU) begin : g_true_lru
        // Age 0 is most recently used; the oldest way carries num_ways-1.
        logic [way_bits-1:0] age_r [num_ways];

        // Age bookkeeping: younger ways than the touched one grow older by one.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int w = 0; w < num_ways; w++) begin
                    age_r[w] <= way_bits'(w);
                end
            end else if (touch) begin
                for (int w = 0; w < num_ways; w++) begin
                    if (way_bits'(w) == way_idx) begin
                        age_r[w] <= '0;
                    end else if (age_r[w] < age_r[way_idx]) begin
                        age_r[w] <= age_r[w] + way_bits'(1);
                    end else begin
                        age_r[w] <= age_r[w];
                    end
                end
            end else begin
                age_r <= age_r;
            end
        end

        // Victim is the way whose age has reached the maximum.
        always_comb begin
            victim = '0;
            for (int w = 0; w < num_ways; w++) begin
                victim = (age_r[w] == way_bits'(num_ways - 1)) ? way_bits'(w) : victim;
            end
        end
    end else begin : g_bit_lru
        logic [num_ways-1:0] mru_r;
        logic [num_ways-1:0] mru_set_s;
        logic [num_ways-1:0] mru_next_s;

        // Set the touched bit; once every bit is set keep only the touched one.
        always_comb begin
            mru_set_s  = mru_r | (num_ways'(1) << way_idx);
            mru_next_s = (&mru_set_s) ? (num_ways'(1) << way_idx) : mru_set_s;
        end

        // MRU bit register.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                mru_r <= '0;
            end else if (touch) begin
                mru_r <= mru_next_s;
            end else begin
                mru_r <= mru_r;
            end
        end

        // Victim is the lowest-index way whose bit is clear (way 0 if none).
        always_comb begin
            victim = '0;
            for (int w = num_ways - 1; w >= 0; w--) begin
                victim = mru_r[w] ? victim : way_bits'(w);
            end
        end
    end

endmodule

// File: rtl/cache.sv
// Set-associative, write-back, write-allocate cache model driven by one trace
// access per clock, with running statistics.
// Optional macro CACHE_TRACE_EN: print one line per processed access.
module cache
    import cache_pkg::*;
#(
    parameter int num_sets           = 32,
    parameter int num_ways           = 8,
    parameter int line_size          = 64,
    parameter int replacement_policy = POLICY_TRUE_LRU
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Access_type,
    input  logic [31:0] Hex_address
);

    localparam int OFF_BITS = addr_bits(line_size);
    localparam int IDX_BITS = addr_bits(num_sets);
    localparam int TAG_BITS = 32 - OFF_BITS - IDX_BITS;
    localparam int SW       = field_width(num_sets);
    localparam int WW       = field_width(num_ways);

    // Statistics, read hierarchically by the bench.
    int  total_number_of_cache_accesses;
    int  number_of_cache_reads;
    int  number_of_cache_writes;
    int  number_of_invalidates;
    int  number_of_cache_hits;
    int  number_of_cache_misses;
    int  number_of_evictions;
    int  number_of_writebacks;
    real cache_hit_ratio;

    // Line state.
    logic [num_ways-1:0] valid_r [num_sets];
    logic [num_ways-1:0] dirty_r [num_sets];
    logic [TAG_BITS-1:0] tag_r   [num_sets][num_ways];

    // Address decode.
    logic [SW-1:0]       set_s;
    logic [TAG_BITS-1:0] tag_s;
    logic                unused_offset_s;

    assign tag_s           = Hex_address[31 -: TAG_BITS];
    assign set_s           = (IDX_BITS > 0) ? Hex_address[OFF_BITS +: SW] : '0;
    assign unused_offset_s = ^Hex_address[OFF_BITS-1:0];

    // Access classification.
    logic is_read_s;
    logic is_write_s;
    logic is_rw_s;
    logic is_inval_s;

    assign is_read_s  = (Access_type == ACC_READ);
    assign is_write_s = (Access_type == ACC_WRITE);
    assign is_rw_s    = is_read_s | is_write_s;
    assign is_inval_s = (Access_type == ACC_INVAL);

    // Lookup results.
    logic          hit_s;
    logic [WW-1:0] hit_way_s;
    logic          free_s;
    logic [WW-1:0] free_way_s;
    logic [WW-1:0] victim_s [num_sets];
    logic [WW-1:0] fill_way_s;
    logic [WW-1:0] touch_way_s;
    logic          victim_dirty_s;

    // Tag match and lowest-index free way in the addressed set.
    always_comb begin
        hit_s      = 1'b0;
        hit_way_s  = '0;
        free_s     = 1'b0;
        free_way_s = '0;
        for (int w = num_ways - 1; w >= 0; w--) begin
            hit_way_s  = (valid_r[set_s][w] && (tag_r[set_s][w] == tag_s)) ? WW'(w) : hit_way_s;
            hit_s      = hit_s | (valid_r[set_s][w] && (tag_r[set_s][w] == tag_s));
            free_way_s = valid_r[set_s][w] ? free_way_s : WW'(w);
            free_s     = free_s | ~valid_r[set_s][w];
        end
    end

    // Fill into a free way first; only a full set consults the policy.
    always_comb begin
        fill_way_s     = free_s ? free_way_s : victim_s[set_s];
        touch_way_s    = hit_s ? hit_way_s : fill_way_s;
        victim_dirty_s = valid_r[set_s][fill_way_s] & dirty_r[set_s][fill_way_s];
    end

    for (genvar s = 0; s < num_sets; s++) begin : g_set
        cache_repl #(
            .num_ways           (num_ways),
            .replacement_policy (replacement_policy),
            .way_bits           (WW)
        ) u_repl (
            .clk     (clk),
            .rst     (rst),
            .touch   (is_rw_s && (set_s == SW'(s))),
            .way_idx (touch_way_s),
            .victim  (victim_s[s])
        );
    end

    // Line state and statistics update, one trace access per clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < num_sets; s++) begin
                valid_r[s] <= '0;
                dirty_r[s] <= '0;
                for (int w = 0; w < num_ways; w++) begin
                    tag_r[s][w] <= '0;
                end
            end
            total_number_of_cache_accesses <= '0;
            number_of_cache_reads          <= '0;
            number_of_cache_writes         <= '0;
            number_of_invalidates          <= '0;
            number_of_cache_hits           <= '0;
            number_of_cache_misses         <= '0;
            number_of_evictions            <= '0;
            number_of_writebacks           <= '0;
        end else begin
            case (Access_type)
                ACC_READ, ACC_WRITE: begin
                    total_number_of_cache_accesses <= sat_inc(total_number_of_cache_accesses);
                    if (is_write_s) begin
                        number_of_cache_writes <= sat_inc(number_of_cache_writes);
                    end else begin
                        number_of_cache_reads <= sat_inc(number_of_cache_reads);
                    end
                    if (hit_s) begin
                        number_of_cache_hits <= sat_inc(number_of_cache_hits);
                        if (is_write_s) begin
                            dirty_r[set_s][hit_way_s] <= 1'b1;
                        end
                    end else begin
                        number_of_cache_misses <= sat_inc(number_of_cache_misses);
                        if (!free_s) begin
                            number_of_evictions <= sat_inc(number_of_evictions);
                        end
                        if (victim_dirty_s) begin
                            number_of_writebacks <= sat_inc(number_of_writebacks);
                        end
                        valid_r[set_s][fill_way_s] <= 1'b1;
                        dirty_r[set_s][fill_way_s] <= is_write_s;
                        tag_r[set_s][fill_way_s]   <= tag_s;
                    end
                end
                ACC_INVAL: begin
                    number_of_invalidates <= sat_inc(number_of_invalidates);
                    if (hit_s) begin
                        if (dirty_r[set_s][hit_way_s]) begin
                            number_of_writebacks <= sat_inc(number_of_writebacks);
                        end
                        valid_r[set_s][hit_way_s] <= 1'b0;
                        dirty_r[set_s][hit_way_s] <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Hit percentage over read/write lookups; zero before any lookup.
    always_comb begin
        if ((number_of_cache_hits == 32'sd0) && (number_of_cache_misses == 32'sd0)) begin
            cache_hit_ratio = 0.0;
        end else begin
            cache_hit_ratio = 100.0 * real'(number_of_cache_hits) /
                              (real'(number_of_cache_hits) + real'(number_of_cache_misses));
        end
    end

`ifdef CACHE_TRACE_EN
    // Per-access trace line.
    always_ff @(posedge clk) begin
        if (!rst && (is_rw_s || is_inval_s)) begin
            $display("%0t %s addr=%h idx=%0d tag=%h %s way=%0d evict=%0d wb=%0d",
                     $time,
                     is_read_s ? "RD" : (is_write_s ? "WR" : "IV"),
                     Hex_address, set_s, tag_s,
                     is_inval_s ? "INV" : (hit_s ? "HIT" : "MISS"),
                     is_inval_s ? hit_way_s : touch_way_s,
                     (is_rw_s && !hit_s && !free_s),
                     is_inval_s ? (hit_s && dirty_r[set_s][hit_way_s]) : (!hit_s && victim_dirty_s));
        end
    end
`endif

endmodule

// File: tb/tb_cache.sv
// Directed self-checking bench for the cache model (default geometry plus a
// 2-way bit-PLRU instance).
module tb_cache;

    localparam logic [31:0] T_RD  = 32'd0;
    localparam logic [31:0] T_WR  = 32'd1;
    localparam logic [31:0] T_INV = 32'd2;
    localparam logic [31:0] T_NOP = 32'd3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] acc_type  = 32'd3;
    logic [31:0] addr      = 32'd0;
    logic [31:0] acc_type2 = 32'd3;
    logic [31:0] addr2     = 32'd0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cache dut (
        .clk         (clk),
        .rst         (rst),
        .Access_type (acc_type),
        .Hex_address (addr)
    );

    cache #(.num_ways(2), .replacement_policy(1)) dut_plru (
        .clk         (clk),
        .rst         (rst),
        .Access_type (acc_type2),
        .Hex_address (addr2)
    );

    task automatic do_acc(input logic [31:0] t, input logic [31:0] a);
        @(negedge clk);
        acc_type = t;
        addr     = a;
        @(negedge clk);
        acc_type = T_NOP;
    endtask

    task automatic do_acc2(input logic [31:0] t, input logic [31:0] a);
        @(negedge clk);
        acc_type2 = t;
        addr2     = a;
        @(negedge clk);
        acc_type2 = T_NOP;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (dut.total_number_of_cache_accesses !== 0 || dut.number_of_cache_misses !== 0 ||
            dut.number_of_cache_hits !== 0 || dut.number_of_writebacks !== 0) begin
            n_fail++;
            $display("FAIL reset_counters: acc=%0d miss=%0d hit=%0d wb=%0d expected all 0",
                     dut.total_number_of_cache_accesses, dut.number_of_cache_misses,
                     dut.number_of_cache_hits, dut.number_of_writebacks);
        end
        n_tests++;
        if (dut.cache_hit_ratio != 0.0) begin
            n_fail++;
            $display("FAIL reset_ratio: got %0.2f expected 0.00", dut.cache_hit_ratio);
        end
        rst = 1'b0;
        do_acc(T_RD, 32'h0);
        do_acc(T_RD, 32'h0);
        n_tests++;
        if (dut.number_of_cache_reads !== 2) begin
            n_fail++;
            $display("FAIL read_twice_reads: got %0d expected 2", dut.number_of_cache_reads);
        end
        n_tests++;
        if (dut.number_of_cache_misses !== 1 || dut.number_of_cache_hits !== 1) begin
            n_fail++;
            $display("FAIL read_twice_hitmiss: miss=%0d hit=%0d expected 1/1",
                     dut.number_of_cache_misses, dut.number_of_cache_hits);
        end
        n_tests++;
        if (dut.cache_hit_ratio != 50.0) begin
            n_fail++;
            $display("FAIL read_twice_ratio: got %0.2f expected 50.00", dut.cache_hit_ratio);
        end
    endtask

    task automatic test_writeback();
        apply_reset();
        do_acc(T_WR, 32'h0);
        for (int i = 1; i < 8; i++) begin
            do_acc(T_RD, 32'h800 * i);
        end
        do_acc(T_RD, 32'h4000);
        n_tests++;
        if (dut.number_of_cache_misses !== 9) begin
            n_fail++;
            $display("FAIL wb_misses: got %0d expected 9", dut.number_of_cache_misses);
        end
        n_tests++;
        if (dut.number_of_evictions !== 1 || dut.number_of_writebacks !== 1) begin
            n_fail++;
            $display("FAIL wb_evict: evict=%0d wb=%0d expected 1/1",
                     dut.number_of_evictions, dut.number_of_writebacks);
        end
        n_tests++;
        if (dut.number_of_cache_writes !== 1 || dut.number_of_cache_reads !== 8 ||
            dut.total_number_of_cache_accesses !== 9) begin
            n_fail++;
            $display("FAIL wb_access_counts: wr=%0d rd=%0d acc=%0d expected 1/8/9",
                     dut.number_of_cache_writes, dut.number_of_cache_reads,
                     dut.total_number_of_cache_accesses);
        end
        do_acc(T_RD, 32'h0);
        n_tests++;
        if (dut.number_of_cache_misses !== 10 || dut.number_of_cache_hits !== 0) begin
            n_fail++;
            $display("FAIL wb_line_gone: miss=%0d hit=%0d expected 10/0",
                     dut.number_of_cache_misses, dut.number_of_cache_hits);
        end
    endtask

    task automatic test_true_lru();
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            do_acc(T_RD, 32'h800 * i);
        end
        do_acc(T_RD, 32'h0);
        do_acc(T_RD, 32'h4000);
        n_tests++;
        if (dut.number_of_evictions !== 1 || dut.number_of_writebacks !== 0) begin
            n_fail++;
            $display("FAIL lru_evict: evict=%0d wb=%0d expected 1/0",
                     dut.number_of_evictions, dut.number_of_writebacks);
        end
        do_acc(T_RD, 32'h0);
        n_tests++;
        if (dut.number_of_cache_hits !== 2) begin
            n_fail++;
            $display("FAIL lru_mru_kept: hits=%0d expected 2", dut.number_of_cache_hits);
        end
        do_acc(T_RD, 32'h800);
        n_tests++;
        if (dut.number_of_cache_misses !== 10 || dut.number_of_evictions !== 2) begin
            n_fail++;
            $display("FAIL lru_victim_gone: miss=%0d evict=%0d expected 10/2",
                     dut.number_of_cache_misses, dut.number_of_evictions);
        end
        do_acc(T_RD, 32'h4000);
        n_tests++;
        if (dut.number_of_cache_hits !== 3) begin
            n_fail++;
            $display("FAIL lru_recent_fill_kept: hits=%0d expected 3", dut.number_of_cache_hits);
        end
    endtask

    task automatic test_invalidate();
        apply_reset();
        do_acc(T_WR, 32'h40);
        do_acc(T_INV, 32'h40);
        do_acc(T_RD, 32'h40);
        n_tests++;
        if (dut.number_of_invalidates !== 1 || dut.number_of_writebacks !== 1) begin
            n_fail++;
            $display("FAIL inv_counts: inv=%0d wb=%0d expected 1/1",
                     dut.number_of_invalidates, dut.number_of_writebacks);
        end
        n_tests++;
        if (dut.total_number_of_cache_accesses !== 2 || dut.number_of_cache_misses !== 2 ||
            dut.number_of_cache_hits !== 0) begin
            n_fail++;
            $display("FAIL inv_reread_miss: acc=%0d miss=%0d hit=%0d expected 2/2/0",
                     dut.total_number_of_cache_accesses, dut.number_of_cache_misses,
                     dut.number_of_cache_hits);
        end
        do_acc(T_INV, 32'h80);
        n_tests++;
        if (dut.number_of_invalidates !== 2 || dut.number_of_writebacks !== 1 ||
            dut.total_number_of_cache_accesses !== 2 || dut.number_of_cache_misses !== 2) begin
            n_fail++;
            $display("FAIL inv_absent: inv=%0d wb=%0d acc=%0d miss=%0d expected 2/1/2/2",
                     dut.number_of_invalidates, dut.number_of_writebacks,
                     dut.total_number_of_cache_accesses, dut.number_of_cache_misses);
        end
        do_acc(32'd7, 32'h40);
        n_tests++;
        if (dut.total_number_of_cache_accesses !== 2 || dut.number_of_cache_reads !== 1 ||
            dut.number_of_invalidates !== 2) begin
            n_fail++;
            $display("FAIL other_type_noop: acc=%0d rd=%0d inv=%0d expected 2/1/2",
                     dut.total_number_of_cache_accesses, dut.number_of_cache_reads,
                     dut.number_of_invalidates);
        end
        do_acc(T_RD, 32'h40);
        n_tests++;
        if (dut.number_of_cache_hits !== 1) begin
            n_fail++;
            $display("FAIL inv_refill_hit: hits=%0d expected 1", dut.number_of_cache_hits);
        end
    endtask

    task automatic test_bit_lru();
        apply_reset();
        do_acc2(T_RD, 32'h0);
        do_acc2(T_RD, 32'h800);
        do_acc2(T_RD, 32'h1000);
        n_tests++;
        if (dut_plru.number_of_evictions !== 1 || dut_plru.number_of_cache_misses !== 3) begin
            n_fail++;
            $display("FAIL plru_evict: evict=%0d miss=%0d expected 1/3",
                     dut_plru.number_of_evictions, dut_plru.number_of_cache_misses);
        end
        do_acc2(T_RD, 32'h800);
        n_tests++;
        if (dut_plru.number_of_cache_hits !== 1) begin
            n_fail++;
            $display("FAIL plru_hit: hits=%0d expected 1", dut_plru.number_of_cache_hits);
        end
        do_acc2(T_RD, 32'h0);
        n_tests++;
        if (dut_plru.number_of_cache_misses !== 4 || dut_plru.number_of_evictions !== 2) begin
            n_fail++;
            $display("FAIL plru_victim_gone: miss=%0d evict=%0d expected 4/2",
                     dut_plru.number_of_cache_misses, dut_plru.number_of_evictions);
        end
        do_acc2(T_RD, 32'h800);
        n_tests++;
        if (dut_plru.number_of_cache_hits !== 2) begin
            n_fail++;
            $display("FAIL plru_mru_kept: hits=%0d expected 2", dut_plru.number_of_cache_hits);
        end
        n_tests++;
        if (dut_plru.cache_hit_ratio != (100.0 * 2.0 / 6.0)) begin
            n_fail++;
            $display("FAIL plru_ratio: got %0.4f expected 33.3333", dut_plru.cache_hit_ratio);
        end
    endtask

    task automatic test_mid_reset();
        apply_reset();
        do_acc(T_WR, 32'h0);
        do_acc(T_RD, 32'h0);
        #3;
        rst = 1'b1;
        #1;
        n_tests++;
        if (dut.total_number_of_cache_accesses !== 0 || dut.number_of_cache_hits !== 0 ||
            dut.number_of_cache_misses !== 0 || dut.number_of_cache_writes !== 0) begin
            n_fail++;
            $display("FAIL async_reset: acc=%0d hit=%0d miss=%0d wr=%0d expected all 0",
                     dut.total_number_of_cache_accesses, dut.number_of_cache_hits,
                     dut.number_of_cache_misses, dut.number_of_cache_writes);
        end
        @(negedge clk);
        rst = 1'b0;
        do_acc(T_RD, 32'h0);
        n_tests++;
        if (dut.number_of_cache_misses !== 1 || dut.number_of_cache_hits !== 0 ||
            dut.number_of_writebacks !== 0) begin
            n_fail++;
            $display("FAIL reset_clears_lines: miss=%0d hit=%0d wb=%0d expected 1/0/0",
                     dut.number_of_cache_misses, dut.number_of_cache_hits,
                     dut.number_of_writebacks);
        end
    endtask

    initial begin
        test_reset();
        test_writeback();
        test_true_lru();
        test_invalidate();
        test_bit_lru();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
